// File: rtl/rs5_amo_responder.sv
// rs5_amo_responder: memory-side responder running plain, LR/SC and AMO requests against a 1-cycle synchronous RAM
module rs5_amo_responder #(
  parameter int          RSV_GRAN     = 2,
  parameter logic [31:0] SC_FAIL_CODE = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req_i,
  input  logic [3:0]  core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [9:0]  core_amo_i,
  input  logic        core_lr_i,
  input  logic        core_sc_i,
  output logic        core_busy_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, MOD = 2'd2, WR = 2'd3;
  localparam int A_NOP = 0, A_SWAP = 1, A_ADD = 2, A_XOR = 3, A_AND = 4, A_OR = 5;
  localparam int A_MIN = 6, A_MAX = 7, A_MINU = 8, A_MAXU = 9;
  localparam int RW = 32 - RSV_GRAN;
  logic [1:0]    state_q, state_d;
  logic          mem_en_q, mem_en_d, rvalid_q, rvalid_d, pass_q, pass_d, rsv_v_q, rsv_v_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rdata_q, rdata_d, amo_new;
  logic [9:0]    op_q, op_d;
  logic [RW-1:0] rsv_a_q, rsv_a_d;
  logic          amo_v, req_hit, mem_hit, w_lt_s, w_gt_s, w_lt_u, w_gt_u;
  assign amo_v   = $onehot(core_amo_i) && !core_amo_i[A_NOP];
  assign req_hit = rsv_v_q && rsv_a_q == core_addr_i[31:RSV_GRAN];
  assign mem_hit = rsv_v_q && rsv_a_q == mem_addr_q[31:RSV_GRAN];
  assign w_lt_s  = $signed(mem_wdata_q) < $signed(mem_rdata_i);
  assign w_gt_s  = $signed(mem_wdata_q) > $signed(mem_rdata_i);
  assign w_lt_u  = mem_wdata_q < mem_rdata_i;
  assign w_gt_u  = mem_wdata_q > mem_rdata_i;
  always_comb begin
    amo_new = op_q[A_SWAP] ? mem_wdata_q :
              op_q[A_ADD]  ? mem_rdata_i + mem_wdata_q :
              op_q[A_XOR]  ? mem_rdata_i ^ mem_wdata_q :
              op_q[A_AND]  ? mem_rdata_i & mem_wdata_q :
              op_q[A_OR]   ? mem_rdata_i | mem_wdata_q :
              op_q[A_MIN]  ? (w_lt_s ? mem_wdata_q : mem_rdata_i) :
              op_q[A_MAX]  ? (w_gt_s ? mem_wdata_q : mem_rdata_i) :
              op_q[A_MINU] ? (w_lt_u ? mem_wdata_q : mem_rdata_i) :
              op_q[A_MAXU] ? (w_gt_u ? mem_wdata_q : mem_rdata_i) : mem_rdata_i;
  end
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    pass_d      = 1'b0;
    op_d        = op_q;
    rsv_v_d     = rsv_v_q;
    rsv_a_d     = rsv_a_q;
    case (state_q)
      IDLE: if (core_req_i) begin
        state_d     = RD;
        mem_en_d    = 1'b1;
        mem_addr_d  = (core_sc_i || core_lr_i || amo_v) ? {core_addr_i[31:2], 2'b00} : core_addr_i;
        mem_wdata_d = core_wdata_i;
        op_d        = (amo_v && !core_sc_i && !core_lr_i) ? core_amo_i : 10'd1;
        if (core_sc_i) begin
          state_d  = WR;
          mem_en_d = req_hit;
          mem_we_d = {4{req_hit}};
          rvalid_d = 1'b1;
          rdata_d  = req_hit ? 32'd0 : SC_FAIL_CODE;
          rsv_v_d  = 1'b0;
        end else if (core_lr_i) begin
          rsv_v_d = 1'b1;
          rsv_a_d = core_addr_i[31:RSV_GRAN];
        end else if (!amo_v && core_we_i != 4'h0) begin
          state_d  = WR;
          mem_we_d = core_we_i;
          rsv_v_d  = rsv_v_q && !req_hit;
        end
      end
      // Plain reads hold RD for the response cycle so no SC can answer right behind the read data.
      RD: begin
        state_d  = !mem_en_q ? IDLE : op_q[A_NOP] ? RD : MOD;
        rvalid_d = mem_en_q && op_q[A_NOP];
        pass_d   = mem_en_q && op_q[A_NOP];
      end
      MOD: begin
        state_d     = WR;
        mem_en_d    = 1'b1;
        mem_we_d    = 4'hF;
        mem_wdata_d = amo_new;
        rdata_d     = mem_rdata_i;
        rvalid_d    = 1'b1;
        rsv_v_d     = rsv_v_q && !mem_hit;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      pass_q      <= 1'b0;
      op_q        <= 10'd1;
      rsv_v_q     <= 1'b0;
      rsv_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      pass_q      <= pass_d;
      op_q        <= op_d;
      rsv_v_q     <= rsv_v_d;
      rsv_a_q     <= rsv_a_d;
    end
  end
  assign core_busy_o   = state_q != IDLE;
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = pass_q ? mem_rdata_i : rdata_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
endmodule
